// File: rtl/prf_pkg.sv
// Shared types for the physical register file read stage.
// Physical register index width and source operand count.
package prf_pkg;

    localparam int PREG_W  = 6;
    localparam int NUM_SRC = 3;

    typedef logic [PREG_W-1:0] preg_t;

endpackage

// File: rtl/prf_operand_bypass.sv
// One operand lane: write/read collision capture plus output mux.
// The RAM returns old data on a same-cycle collision, so the write is replayed here.
module prf_operand_bypass
    import prf_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wb_hit,
    input  logic [WIDTH-1:0] i_wb_data,
    input  logic             i_s1_valid,
    input  preg_t            i_s1_src,
    input  logic [WIDTH-1:0] i_ram_dout,
    output logic [WIDTH-1:0] o_data
);

    logic             r_hit;
    logic [WIDTH-1:0] r_data;
    logic             w_zero;

    // Capture a write that collided with this lane's read in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit  <= 1'b0;
            r_data <= '0;
        end else begin
            r_hit  <= i_wb_hit;
            r_data <= i_wb_data;
        end
    end

    assign w_zero = ZERO_REG && (i_s1_src == '0);

    // Operand select: masked when idle, zero register, then bypass, then RAM.
    always_comb begin
        o_data = '0;
        if (i_s1_valid && !w_zero) begin
            o_data = r_hit ? r_data : i_ram_dout;
        end
    end

endmodule

// File: rtl/prf_read_stage.sv
// Operand-read stage between issue and execute for a 64-entry 3R1W PRF.
// Holds one uop, re-reads its sources while stalled, and bypasses colliding writes.
module prf_read_stage
    import prf_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int PAYLOAD_W = 64,
    parameter bit ZERO_REG  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  preg_t                in_src0,
    input  preg_t                in_src1,
    input  preg_t                in_src2,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic                 wb_valid,
    input  preg_t                wb_addr,
    input  logic [WIDTH-1:0]     wb_data,
    output preg_t                ram_addr0,
    output preg_t                ram_addr1,
    output preg_t                ram_addr2,
    output preg_t                ram_addrw,
    output logic [WIDTH-1:0]     ram_din,
    output logic                 ram_wea,
    input  logic [WIDTH-1:0]     ram_dout0,
    input  logic [WIDTH-1:0]     ram_dout1,
    input  logic [WIDTH-1:0]     ram_dout2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data0,
    output logic [WIDTH-1:0]     out_data1,
    output logic [WIDTH-1:0]     out_data2,
    output logic [PAYLOAD_W-1:0] out_payload
);

    logic                 r_s1_valid;
    preg_t                r_s1_src [NUM_SRC];
    logic [PAYLOAD_W-1:0] r_s1_payload;

    logic                 w_accept;
    logic                 w_wea;
    preg_t                w_in_src [NUM_SRC];
    preg_t                w_addr   [NUM_SRC];
    logic                 w_hit    [NUM_SRC];
    logic [WIDTH-1:0]     w_dout   [NUM_SRC];
    logic [WIDTH-1:0]     w_data   [NUM_SRC];

    // Flush forces ready so issue never blocks on a squashed uop.
    assign in_ready = flush | ~r_s1_valid | out_ready;
    assign w_accept = in_valid & in_ready & ~flush;

    assign w_wea = wb_valid & ~(ZERO_REG && (wb_addr == '0));

    assign w_in_src[0] = in_src0;
    assign w_in_src[1] = in_src1;
    assign w_in_src[2] = in_src2;
    assign w_dout[0]   = ram_dout0;
    assign w_dout[1]   = ram_dout1;
    assign w_dout[2]   = ram_dout2;

    // Read the incoming uop on accept, otherwise keep re-reading the held one.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            w_addr[i] = w_accept ? w_in_src[i] : r_s1_src[i];
            w_hit[i]  = w_wea && (wb_addr == w_addr[i]);
        end
    end

    // Hold register: load on accept, clear on flush or drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid   <= 1'b0;
            r_s1_payload <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                r_s1_src[i] <= '0;
            end
        end else if (flush) begin
            r_s1_valid <= 1'b0;
        end else if (w_accept) begin
            r_s1_valid   <= 1'b1;
            r_s1_payload <= in_payload;
            for (int i = 0; i < NUM_SRC; i++) begin
                r_s1_src[i] <= w_in_src[i];
            end
        end else if (r_s1_valid && out_ready) begin
            r_s1_valid <= 1'b0;
        end
    end

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_lane
        prf_operand_bypass #(
            .WIDTH    (WIDTH),
            .ZERO_REG (ZERO_REG)
        ) u_byp (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_wb_hit   (w_hit[g]),
            .i_wb_data  (wb_data),
            .i_s1_valid (r_s1_valid),
            .i_s1_src   (r_s1_src[g]),
            .i_ram_dout (w_dout[g]),
            .o_data     (w_data[g])
        );
    end

    assign ram_addr0   = w_addr[0];
    assign ram_addr1   = w_addr[1];
    assign ram_addr2   = w_addr[2];
    assign ram_addrw   = wb_addr;
    assign ram_din     = wb_data;
    assign ram_wea     = w_wea;

    assign out_valid   = r_s1_valid;
    assign out_data0   = w_data[0];
    assign out_data1   = w_data[1];
    assign out_data2   = w_data[2];
    assign out_payload = r_s1_payload;

endmodule
